// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULDIV_DIV_EN enables the divide datapath; without it only MULT/MULTU are accepted.
package muldiv_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ITER       = DATA_W_DEF;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  // op[0] clear selects the signed variant of both MULT and DIV
  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The divide half exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                  is_div_i,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     opnd_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W:0]      sum;
  logic [2*DATA_W-1:0]  mul_nxt;
  logic [2*DATA_W-1:0]  div_nxt;

  // acc = {partial product, unconsumed multiplier bits}; carry lands in the top bit
  assign sum     = {1'b0, acc_i[2*DATA_W-1:DATA_W]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
  assign mul_nxt = {sum, acc_i[DATA_W-1:1]};

`ifdef MULDIV_DIV_EN
  logic [DATA_W:0] diff;
  logic            q_bit;

  // acc = {remainder, unconsumed dividend bits}; quotient bits enter at the LSB
  assign diff    = acc_i[2*DATA_W-1:DATA_W-1] - {1'b0, opnd_i};
  assign q_bit   = ~diff[DATA_W];
  assign div_nxt = {(q_bit ? diff[DATA_W-1:0] : acc_i[2*DATA_W-2:DATA_W-1]),
                    acc_i[DATA_W-2:0], q_bit};
`else
  assign div_nxt = acc_i;
`endif

  assign acc_o = is_div_i ? div_nxt : mul_nxt;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide with HI/LO result registers and one LO write-back.
// MULDIV_DIV_EN adds DIV/DIVU; otherwise divide ops are rejected with an illegal pulse.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [4:0]        dst_addr,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              illegal,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              wb_we,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CW = $clog2(DATA_W);

  state_e                state_q;
  logic                  sgn_q, div_q, neg_q, rneg_q;
  logic [DATA_W-1:0]     src_a_q, src_b_q, opnd_q;
  logic [4:0]            dst_q;
  logic [2*DATA_W-1:0]   acc_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_W-1:0]     hi_q, lo_q, wb_data_q;
  logic [4:0]            wb_addr_q;
  logic                  busy_q, done_q, ill_q, dz_q, wb_we_q;

  logic [DATA_W-1:0]     abs_a, abs_b;
  logic                  sa, sb;
  logic [2*DATA_W-1:0]   step_acc, prod;
  logic [DATA_W-1:0]     quo, rem, hi_d, lo_d;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div_i (div_q),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc)
  );

  always_comb begin
    sa    = sgn_q & src_a_q[DATA_W-1];
    sb    = sgn_q & src_b_q[DATA_W-1];
    abs_a = sa ? -src_a_q : src_a_q;
    abs_b = sb ? -src_b_q : src_b_q;
    prod  = neg_q  ? -acc_q : acc_q;
    quo   = neg_q  ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem   = rneg_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    hi_d  = prod[2*DATA_W-1:DATA_W];
    lo_d  = prod[DATA_W-1:0];
    if (div_q) begin
      // divide by zero is defined rather than trapped
      if (src_b_q == '0) begin
        hi_d = src_a_q;
        lo_d = '1;
      end else begin
        hi_d = rem;
        lo_d = quo;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sgn_q     <= 1'b0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      opnd_q    <= '0;
      dst_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ill_q     <= 1'b0;
      dz_q      <= 1'b0;
      wb_we_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wb_we_q <= 1'b0;
      ill_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          if (op[1] && !DIV_EN) begin
            ill_q <= 1'b1;
          end else begin
            sgn_q   <= op_is_signed(op);
            div_q   <= DIV_EN && op[1];
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst_addr;
            dz_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_PREP;
          end
        end
        S_PREP: begin
          acc_q   <= {{DATA_W{1'b0}}, (div_q ? abs_a : abs_b)};
          opnd_q  <= div_q ? abs_b : abs_a;
          neg_q   <= sa ^ sb;
          rneg_q  <= sa;
          cnt_q   <= '0;
          state_q <= S_CALC;
        end
        S_CALC: begin
          acc_q <= step_acc;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          dz_q    <= div_q && (src_b_q == '0);
          done_q  <= 1'b1;
          if (dst_q != 5'd0) begin
            wb_we_q   <= 1'b1;
            wb_addr_q <= dst_q;
            wb_data_q <= lo_d;
          end
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = ill_q;
  assign div_zero = DIV_EN ? dz_q : 1'b0;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign wb_we    = wb_we_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic reference model.
// Divide coverage follows MULDIV_DIV_EN; without it divide ops must be rejected.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic [4:0]  dst_addr = '0;
  logic        busy, done, div_zero, illegal, wb_we;
  logic [31:0] hi, lo, wb_data;
  logic [4:0]  wb_addr;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_addr(dst_addr), .busy(busy), .done(done), .div_zero(div_zero), .illegal(illegal),
    .hi(hi), .lo(lo), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain-arithmetic reference for the four ops
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    logic [63:0] p;
    int sa, sb;
    edz = 1'b0;
    sa  = a;
    sb  = b;
    case (o)
      2'b00: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        eh = p[63:32]; el = p[31:0];
      end
      2'b01: begin
        p = {32'b0, a} * {32'b0, b};
        eh = p[63:32]; el = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; edz = 1'b1;
        end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          eh = 32'd0; el = 32'h8000_0000;
        end else if (o == 2'b10) begin
          el = sa / sb; eh = sa % sb;
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endtask

  // hold=1 keeps start asserted (with junk operands) through the DONE cycle
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input bit hold);
    logic [31:0] eh, el;
    logic        edz;
    int          n;
    bit          stable, spur, busy_ok;
    model(o, a, b, eh, el, edz);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dst_addr = d;
    @(posedge clk); #1;
    chk("busy_rise", busy, 1);
    if (!hold) start = 1'b0;
    else begin
      op = 2'b01; src_a = $urandom; src_b = $urandom; dst_addr = 5'd9;
    end
    n = 0; stable = 1; spur = 0; busy_ok = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!done && (hi !== last_hi || lo !== last_lo)) stable = 0;
      if (!done && wb_we) spur = 1;
      if (!busy) busy_ok = 0;
    end
    chk("latency", n, 34);
    chk("hilo_stable", stable, 1);
    chk("early_we", spur, 0);
    chk("busy_hold", busy_ok, 1);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_zero", div_zero, edz);
    chk("wb_we", wb_we, d != 5'd0);
    if (d != 5'd0) begin
      chk("wb_addr", wb_addr, d);
      chk("wb_data", wb_data, el);
    end
    last_hi = eh; last_lo = el;
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("wb_we_pulse", wb_we, 0);
    chk("busy_fall", busy, 0);
    start = 1'b0;
    if (hold) begin
      spur = 0;
      repeat (3) begin
        @(posedge clk); #1;
        if (done || busy || wb_we) spur = 1;
      end
      chk("no_requeue", spur, 0);
    end
  endtask

  task automatic abort_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; dst_addr = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_wb", {wb_we, wb_addr, wb_data}, 0);
    chk("rst_flags", {div_zero, illegal}, 0);
    @(negedge clk) rst_n = 1'b1;
    last_hi = '0; last_lo = '0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || wb_we || busy) seen = 1;
    end
    chk("abort_quiet", seen, 0);
  endtask

`ifndef MULDIV_DIV_EN
  task automatic illegal_op(input logic [1:0] o);
    @(negedge clk);
    start = 1'b1; op = o; src_a = $urandom; src_b = $urandom; dst_addr = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_busy", busy, 0);
    @(posedge clk); #1;
    chk("ill_clear", illegal, 0);
    chk("ill_idle", {busy, done, wb_we, div_zero}, 0);
    chk("ill_hi", hi, last_hi);
    chk("ill_lo", lo, last_lo);
  endtask
`endif

  initial begin
    logic [31:0] ra, rb;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_out", {done, div_zero, illegal, wb_we}, 0);
    chk("reset_hilo", {hi, lo}, 0);
    chk("reset_wb", {wb_addr, wb_data}, 0);
    @(negedge clk) rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5'd5, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(2'b00, 32'h1234_5678, 32'd0, 5'd2, 0);
    run_op(2'b00, $urandom, $urandom, 5'd0, 1);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = (i % 4 == 0) ? $urandom_range(0, 15) : $urandom;
      run_op(2'($urandom_range(0, 1)), ra, rb, 5'($urandom_range(0, 31)), 0);
    end

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd8, 0);
    run_op(2'b11, 32'h1234, 32'd0, 5'd9, 0);
    run_op(2'b00, 32'd5, 32'd6, 5'd10, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(2'b10, 32'h8000_0000, 32'd0, 5'd12, 0);
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 100) : $urandom);
      run_op(2'($urandom_range(2, 3)), ra, rb, 5'($urandom_range(0, 31)), 0);
    end
    abort_op(2'b10, 32'hDEAD_BEEF, 32'd17);
`else
    illegal_op(2'b10);
    illegal_op(2'b11);
    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5'd5, 0);
    abort_op(2'b01, 32'hDEAD_BEEF, 32'd17);
`endif
    run_op(2'b01, 32'd123456, 32'd654321, 5'd31, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the CPU execute stage. Consumes the two source operands read from the register file, computes over a fixed multi-cycle sequence, holds the 64-bit result in internal HI/LO registers, and issues one write-back of LO to the register file's write port. Busy stalls issue upstream while an operation is in flight.

## Interface
Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  issue request; sampled only in IDLE
- op  in  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU
- src_a  in  DATA_W  rs operand (multiplicand/dividend)
- src_b  in  DATA_W  rt operand (multiplier/divisor)
- dst_addr  in  5  write-back register address, latched at start
- busy  out  1  operation in flight (PREP..DONE)
- done  out  1  one-cycle completion pulse
- div_zero  out  1  sticky for result: last divide had src_b == 0
- illegal  out  1  one-cycle pulse: rejected op
- hi  out  DATA_W  HI result register
- lo  out  DATA_W  LO result register
- wb_we  out  1  register-file write enable
- wb_addr  out  5  register-file write address
- wb_data  out  DATA_W  register-file write data (= new LO)

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE: on start, latch op, src_a, src_b, dst_addr; go PREP.
- PREP: signed ops take absolute values, record result signs (mult: sign_a^sign_b; div quotient: sign_a^sign_b, remainder: sign_a); clear accumulator, count = 0; go CALC.
- CALC: one radix-2 step per cycle. Multiply: shift-add into 64-bit accumulator. Divide: restoring shift-subtract, quotient bit into LSB. After DATA_W steps (count == DATA_W-1) go FIX.
- FIX: two's-complement negate per recorded signs; write HI/LO (mult: HI = upper, LO = lower; div: HI = remainder, LO = quotient); go DONE.
- DONE: done=1; wb_we=1 unless dst_addr == 0; go IDLE.
- Divide by zero: no trap; HI = src_a, LO = all ones, div_zero=1, normal latency. div_zero clears on next accepted start.
- Signed 0x80000000 / -1: LO = 0x80000000, HI = 0, no flag.
- Counter width $clog2(DATA_W); accumulator 2*DATA_W; no other widening.

## Timing
- Reset (async, any state, including mid-CALC): state IDLE; busy, done, illegal, wb_we, div_zero = 0; hi, lo, wb_data = 0; wb_addr = 0. Aborted operation leaves no write-back.
- Start sampled at edge E0 → busy high after E0. Done and wb_we high for exactly the one cycle after edge E0+34; busy falls after E0+35.
- hi/lo change only at the FIX→DONE edge; stable otherwise.
- start while busy (including the DONE cycle): ignored, no queuing.
- Back-to-back: start may be sampled at the first IDLE edge after DONE.
- wb_data/wb_addr valid whenever wb_we is high; hold last values otherwise.

## Configuration
- MULDIV_DIV_EN defined: all four ops supported as above.
- Not defined: divide datapath omitted; start with op[1]=1 is rejected in IDLE: illegal pulses one cycle, state stays IDLE, busy stays low, hi/lo/div_zero unchanged. div_zero tied 0.

## Structure
- Package muldiv_pkg: op encoding constants, state enum, DATA_W default, ITER count.
- Sub-module muldiv_step: combinational single-iteration datapath (add or subtract-compare on accumulator, next accumulator and quotient bit), instantiated once in muldiv_unit.

## Test plan
- MULT 0xFFFFFFFE × 3, dst 5 → after 34 cycles done, HI=0xFFFFFFFF, LO=0xFFFFFFFA, wb_we with addr 5, data 0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100 / 7 → LO=14, HI=2.
- DIVU 0x1234 / 0 → HI=0x1234, LO=0xFFFFFFFF, div_zero=1; following MULT clears div_zero.
- start re-asserted every cycle during a MULT, dst 0 → single completion, no wb_we; rst_n pulled low at cycle 15 of a DIV → all outputs 0, no done.
- Build without MULDIV_DIV_EN: DIV start → illegal one cycle, busy 0, hi/lo unchanged; MULT still correct.
